// File: rtl/smpte_pattern_gen.sv
// smpte_pattern_gen: multi-mode registered test-pattern generator (SMPTE layout, 100% bars, checkerboard, black)
// Ports:
//   clk, reset            pixel clock; asynchronous active-low reset
//   hpos, vpos            beam position from hvsync_generator (PW bits)
//   display_on            visible-region flag
//   mode_in, mode_valid   pattern request (0 SMPTE, 1 100% bars, 2 checkerboard, 3 black)
//   mode_ready            high while no mode change is pending
//   mode_active           pattern on screen; changes only at vpos==V_ACTIVE && hpos==0
//   bar_idx, de_out, rgb  registered pixel outputs, one cycle after their inputs
// Build option: define TPG_SCROLL_EN to rotate the bars by one every 2^SCROLL_SHIFT frames.
module smpte_pattern_gen #(
    parameter int H_ACTIVE     = 256,
    parameter int V_ACTIVE     = 240,
    parameter int NUM_BARS     = 7,
    parameter int CW           = 2,
    parameter int PW           = 9,
    parameter int SCROLL_SHIFT = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PW-1:0]   hpos,
    input  logic [PW-1:0]   vpos,
    input  logic            display_on,
    input  logic [1:0]      mode_in,
    input  logic            mode_valid,
    output logic            mode_ready,
    output logic [1:0]      mode_active,
    output logic [3:0]      bar_idx,
    output logic            de_out,
    output logic [3*CW-1:0] rgb
);
    localparam int            BAR_W    = H_ACTIVE / NUM_BARS;
    localparam logic [CW-1:0] FULL     = CW'((1 << CW) - 1);
    localparam logic [CW-1:0] L75      = CW'((3 * ((1 << CW) - 1)) / 4);
    localparam logic [PW-1:0] V_TOP    = PW'(2 * V_ACTIVE / 3);
    localparam logic [PW-1:0] V_MID    = PW'(3 * V_ACTIVE / 4);
    localparam logic [PW-1:0] V_END    = PW'(V_ACTIVE);
    localparam logic [PW-1:0] PX_LAST  = PW'(BAR_W - 1);
    localparam logic [3:0]    BAR_LAST = 4'(NUM_BARS - 1);

    if (NUM_BARS < 2 || NUM_BARS > 16 || SCROLL_SHIFT < 0) begin : g_bad_param
        $error("smpte_pattern_gen: NUM_BARS must be 2..16 and SCROLL_SHIFT >= 0");
    end

    logic [PW-1:0] px_cnt, px_cur;
    logic [3:0]    bar_cnt, bar_cur, bar_eff;
    logic [2:0]    bar_m7, bar_on, cast_on, on;
    logic [1:0]    pend_mode;
    logic          pend_v, accept, boundary, bar_end;
    logic [CW-1:0] lvl;

    assign boundary   = vpos == V_END && hpos == '0;
    assign accept     = mode_valid && !pend_v;
    assign mode_ready = !pend_v;
    // hpos==0 restarts the bar walk in the same cycle, so every line starts on bar 0
    assign px_cur  = hpos == '0 ? '0 : px_cnt;
    assign bar_cur = hpos == '0 ? '0 : bar_cnt;
    assign bar_end = display_on && px_cur == PX_LAST;

`ifdef TPG_SCROLL_EN
    localparam logic [SCROLL_SHIFT:0] FRM_LAST = (SCROLL_SHIFT + 1)'((1 << SCROLL_SHIFT) - 1);
    logic [SCROLL_SHIFT:0] frm;
    logic [3:0]            rot;
    logic [4:0]            bar_sum;
    assign bar_sum = {1'b0, bar_cur} + {1'b0, rot};
    assign bar_eff = bar_sum >= 5'(NUM_BARS) ? 4'(bar_sum - 5'(NUM_BARS)) : bar_sum[3:0];
    // Any applied mode request restarts the scroll from the unrotated layout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frm <= '0;
            rot <= '0;
        end else if (boundary) begin
            frm <= pend_v || frm == FRM_LAST ? '0 : frm + (SCROLL_SHIFT + 1)'(1);
            rot <= pend_v || (frm == FRM_LAST && rot == BAR_LAST) ? '0 : rot + 4'(frm == FRM_LAST);
        end
    end
`else
    assign bar_eff = bar_cur;
`endif

    assign bar_m7  = 3'(bar_eff >= 4'd14 ? bar_eff - 4'd14 : bar_eff >= 4'd7 ? bar_eff - 4'd7 : bar_eff);
    // Palette index k: R for k in {0,1,4,5}, G for k<4, B for even k.
    assign bar_on  = {~bar_m7[1], ~bar_m7[2], ~bar_m7[0]};
    // Castellation strip shows palette colour 6-k on even bars, black on odd bars.
    assign cast_on = bar_m7[0] ? 3'b000 : {bar_m7[1], bar_m7[2], 1'b1};
    assign on  = mode_active == 2'd0 ? (vpos < V_TOP ? bar_on : vpos < V_MID ? cast_on : {3{bar_eff == 4'd1}})
               : mode_active == 2'd1 ? bar_on
               : mode_active == 2'd2 ? {3{hpos[3] ^ vpos[3]}}
               : 3'b000;
    assign lvl = mode_active == 2'd0 && vpos < V_MID ? L75 : FULL;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            px_cnt      <= '0;
            bar_cnt     <= '0;
            bar_idx     <= '0;
            de_out      <= 1'b0;
            rgb         <= '0;
            mode_active <= 2'd0;
            pend_mode   <= 2'd0;
            pend_v      <= 1'b0;
        end else begin
            px_cnt      <= bar_end ? '0 : px_cur + PW'(display_on);
            bar_cnt     <= bar_end && bar_cur != BAR_LAST ? bar_cur + 4'd1 : bar_cur;
            bar_idx     <= bar_eff;
            de_out      <= display_on;
            rgb         <= display_on ? {{CW{on[2]}} & lvl, {CW{on[1]}} & lvl, {CW{on[0]}} & lvl} : '0;
            mode_active <= boundary && pend_v ? pend_mode : mode_active;
            pend_mode   <= accept ? mode_in : pend_mode;
            pend_v      <= accept || (pend_v && !boundary);
        end
    end
endmodule

// File: tb/tb_smpte_pattern_gen.sv
// tb_smpte_pattern_gen: scoreboard bench for smpte_pattern_gen against a frame-level reference model
module tb_smpte_pattern_gen;
    localparam int H  = 256;
    localparam int V  = 240;
    localparam int NB = 7;
    localparam int CW = 2;
    localparam int PW = 9;
    localparam int SS = 6;
    localparam int BW = H / NB;
    localparam int FULL = (1 << CW) - 1;
    localparam int L75  = 3 * FULL / 4;
    // {R,G,B} on-flags: palette by bar, and the castellation strip by bar
    localparam bit [2:0] PALETTE [7] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001};
    localparam bit [2:0] CASTLE  [7] = '{3'b001, 3'b000, 3'b101, 3'b000, 3'b011, 3'b000, 3'b111};

    logic            clk = 1'b0, reset = 1'b0;
    logic [PW-1:0]   hpos = '0, vpos = '0;
    logic            display_on = 1'b0, mode_valid = 1'b0;
    logic [1:0]      mode_in = 2'd0;
    logic            mode_ready, de_out;
    logic [1:0]      mode_active;
    logic [3:0]      bar_idx;
    logic [3*CW-1:0] rgb;

    smpte_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .NUM_BARS(NB), .CW(CW), .PW(PW), .SCROLL_SHIFT(SS)) dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .mode_in(mode_in), .mode_valid(mode_valid), .mode_ready(mode_ready),
        .mode_active(mode_active), .bar_idx(bar_idx), .de_out(de_out), .rgb(rgb)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3*CW-1:0] rgb;
        logic            de;
        logic [3:0]      bar;
        logic [1:0]      mode;
        logic            ready;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int n_cmp = 0, n_bad = 0;
    int m_active = 0, m_pend = 0, m_pv = 0, m_cnt = 0, m_frames = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [3*CW-1:0] paint(input bit [2:0] f, input int lvl);
        logic [CW-1:0] l = CW'(lvl);
        return {{CW{f[2]}} & l, {CW{f[1]}} & l, {CW{f[0]}} & l};
    endfunction

    function automatic logic [3*CW-1:0] model_rgb(input int mode, input int b, input int h, input int v);
        int c = b % 7;
        bit chk = ((h / 8) % 2) != ((v / 8) % 2);
        case (mode)
            0: begin
                if (v < 2 * V / 3) return paint(PALETTE[c], L75);
                if (v < 3 * V / 4) return paint(CASTLE[c], L75);
                return paint(b == 1 ? 3'b111 : 3'b000, FULL);
            end
            1: return paint(PALETTE[c], FULL);
            2: return paint({3{chk}}, FULL);
            default: return '0;
        endcase
    endfunction

    // Drive one pixel cycle, predict the registered response and queue it.
    task automatic step(input int h, input int v, input bit de, input bit mv, input int mi);
        int n_cur, b, rot;
        bit acc;
        exp_t e;
        hpos = PW'(h); vpos = PW'(v); display_on = de; mode_valid = mv; mode_in = 2'(mi);
`ifdef TPG_SCROLL_EN
        rot = (m_frames >> SS) % NB;
`else
        rot = 0;
`endif
        n_cur = h == 0 ? 0 : m_cnt;
        b = n_cur / BW < NB - 1 ? n_cur / BW : NB - 1;
        b = (b + rot) % NB;
        e.rgb = de ? model_rgb(m_active, b, h, v) : '0;
        e.de  = de;
        e.bar = 4'(b);
        m_cnt = de ? n_cur + 1 : n_cur;
        acc = mv && m_pv == 0;
        if (h == 0 && v == V) begin
            m_frames = m_pv != 0 ? 0 : m_frames + 1;
            if (m_pv != 0) m_active = m_pend;
            m_pv = 0;
        end
        if (acc) begin
            m_pend = mi;
            m_pv = 1;
        end
        e.mode  = 2'(m_active);
        e.ready = m_pv == 0;
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    task automatic line(input int v, input int drop, input int req_h, input int req_m, input bit hold);
        for (int h = 0; h < H + 8; h++)
            step(h, v, h < H && int'($urandom_range(99)) >= drop,
                 req_h >= 0 && (h == req_h || (hold && h > req_h)), req_m);
    endtask

    task automatic frame_end(input bit mv, input int mi);
        step(0, V, 1'b0, mv, mi);
        step(1, V, 1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("async_rst_rgb", int'(rgb), 0);
        check("async_rst_de", int'(de_out), 0);
        check("async_rst_mode", int'(mode_active), 0);
        check("async_rst_ready", int'(mode_ready), 1);
        m_active = 0; m_pend = 0; m_pv = 0; m_cnt = 0; m_frames = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: compares every registered output cycle against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            check("rgb", int'(rgb), int'(mon_e.rgb));
            check("de_out", int'(de_out), int'(mon_e.de));
            check("bar_idx", int'(bar_idx), int'(mon_e.bar));
            check("mode_active", int'(mode_active), int'(mon_e.mode));
            check("mode_ready", int'(mode_ready), int'(mon_e.ready));
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        check("reset_rgb", int'(rgb), 0);
        check("reset_bar", int'(bar_idx), 0);
        check("reset_mode", int'(mode_active), 0);
        check("reset_ready", int'(mode_ready), 1);
        line(10, 0, -1, 0, 0);
        line(170, 0, -1, 0, 0);
        line(200, 0, -1, 0, 0);
        line(50, 0, 20, 1, 0);
        line(60, 0, 5, 2, 1);
        frame_end(1'b0, 0);
        line(10, 0, -1, 0, 0);
        frame_end(1'b1, 2);
        line(100, 0, -1, 0, 0);
        frame_end(1'b0, 0);
        line(5, 0, -1, 0, 0);
        line(12, 20, -1, 0, 0);
        frame_end(1'b1, 0);
        repeat (70) frame_end(1'b0, 0);
        line(30, 0, -1, 0, 0);
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(3))
                0, 1: line(int'($urandom_range(V - 1)), 10,
                           $urandom_range(2) == 0 ? int'($urandom_range(H - 1)) : -1,
                           int'($urandom_range(3)), 1'($urandom_range(1)));
                2: frame_end(1'($urandom_range(1)), int'($urandom_range(3)));
                default: repeat (int'($urandom_range(1, 8))) frame_end(1'b0, 0);
            endcase
        end
        line(20, 0, 3, 3, 0);
        frame_end(1'b0, 0);
        line(100, 0, 10, 1, 0);
        for (int h = 0; h < 100; h++) step(h, 120, 1'b1, 1'b0, 0);
        do_reset();
        line(10, 0, -1, 0, 0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/smpte_pattern_gen.md
Name: smpte_pattern_gen

Overview:
Parametrised multi-mode test-pattern generator; successor to the fixed 1-bit, 7-bar colour-bar block. Consumes beam position and display_on from hvsync_generator and produces registered multi-bit RGB, with selectable patterns, a full three-region SMPTE layout, arbitrary bar count and width, and frame-synchronous mode switching via a valid/ready handshake. Sits between hvsync_generator and the DAC/output pins.

Parameters:
H_ACTIVE, 256, visible pixels per line
V_ACTIVE, 240, visible lines per frame
NUM_BARS, 7, bar count (2..16); BAR_W = H_ACTIVE/NUM_BARS (localparam); remainder pixels extend the last bar
CW, 2, bits per colour channel; FULL = 2^CW-1, L75 = (3*FULL)/4 (localparams)
PW, 9, width of hpos/vpos
SCROLL_SHIFT, 6, frames per scroll step = 2^SCROLL_SHIFT (used only with TPG_SCROLL_EN)

Ports:
clk  in  1  pixel clock, same as hvsync_generator
reset  in  1  asynchronous, active-low reset
hpos  in  PW  horizontal beam position
vpos  in  PW  vertical beam position
display_on  in  1  visible-region flag
mode_in  in  2  requested pattern: 0 SMPTE, 1 100% bars, 2 checkerboard, 3 black
mode_valid  in  1  mode request strobe
mode_ready  out  1  high when no mode change is pending
mode_active  out  2  pattern currently displayed
bar_idx  out  4  registered effective bar index of the current pixel
de_out  out  1  display_on delayed one cycle
rgb  out  3*CW  {R,G,B}, each CW bits, registered

Behaviour:
- Reset (reset=0, async): rgb=0, de_out=0, bar_idx=0, mode_active=0, pending cleared, mode_ready=1, pixel/bar counters and scroll rotation =0.
- Latency: exactly 1 cycle. rgb/de_out/bar_idx at t+1 reflect inputs at t. rgb=0 whenever display_on was 0.
- Bar counter (no divider): at hpos==0, px_cnt=0 and bar=0. Each display_on cycle, px_cnt increments; at px_cnt==BAR_W-1, px_cnt=0 and bar increments, saturating at NUM_BARS-1.
- Colour order for bar b mod 7: white, yellow, cyan, green, magenta, red, blue. R on for b in {0,1,4,5}; G on for {0..3}; B on for {0,2,4,6}.
- Mode 0 (SMPTE), vertical regions:
  - vpos < 2*V_ACTIVE/3: bars at L75.
  - vpos < 3*V_ACTIVE/4: castellation strip at L75, blue/black/magenta/black/cyan/black/white by bar.
  - Else PLUGE row: bar 1 = FULL white; all other bars black.
- Mode 1: full-height bars at FULL.
- Mode 2: checkerboard; all channels FULL when hpos[3]^vpos[3]=1, else 0.
- Mode 3: black; de_out still toggles.
- Handshake: a transfer occurs when mode_valid && mode_ready. mode_in goes to the pending register and mode_ready drops next cycle.
- Frame boundary: the cycle with vpos==V_ACTIVE && hpos==0. Here mode_active <= pending, pending clears, and mode_ready=1 next cycle.
- Request accepted in the boundary cycle itself: applies at the next boundary.
- mode_valid while mode_ready=0: ignored. The requester must hold it.
- The mode never changes mid-frame.
- Reset mid-frame: immediately black, mode 0, pending lost.

Optional Feature:
TPG_SCROLL_EN:
- Defined:
  - rot counter increments at every 2^SCROLL_SHIFT-th frame boundary, wrapping NUM_BARS-1 -> 0.
  - Effective bar = (bar + rot) mod NUM_BARS, computed by compare/subtract, not division. Applies in modes 0/1 and to bar_idx.
  - A mode change clears rot.
- Undefined: rot is absent, effective bar = bar, and SCROLL_SHIFT is unused.

Test Plan:
- Defaults, mode 0. Sample hpos 0, 36, 216, 255 with vpos 10. Required rgb one cycle later: 6'b101010, 6'b101000, 6'b000010, 6'b000010.
- vpos 170, hpos 36 -> black; hpos 72 -> 6'b100010 (magenta). vpos 200, hpos 40 -> 6'b111111; hpos 0 -> 0.
- Pulse mode_valid with mode_in=1 at vpos 50. Required: mode_ready=0 next cycle; mode_active stays 0 until the vpos==240 && hpos==0 boundary, then 1; hpos 0 gives 6'b111111 in the next frame.
- Request at the boundary cycle itself -> applied one frame later. A second mode_valid while pending is ignored.
- display_on=0 with any hpos -> rgb=0, de_out=0. Assert reset mid-line -> rgb=0 and mode_active=0 asynchronously, mode_ready=1.
- TPG_SCROLL_EN with SCROLL_SHIFT=0: after 1 frame, hpos 0 gives yellow (6'b101000). After 7 frames it wraps back to white.
